// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: definitions shared by the fetch stage and its neighbours.
//   fetch_state_t    : fetch FSM encodings (FS_FETCH / FS_HOLD / FS_HALTED)
//   OPC_MSB/OPC_LSB  : opcode field position inside a 16-bit instruction word
//   RESET_PC_DEFAULT : PC loaded on reset unless overridden
//   opcode_of()      : slices the opcode so fetch and decode agree on the field
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FS_FETCH  = 2'd0,
        FS_HOLD   = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_t;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    function automatic logic [3:0] opcode_of(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// instr_fetch_pc_reg: program counter with load / increment / hold.
// Increment wraps modulo 2^ADDR_W. Load has priority over increment.
//   clk      in   clock
//   rst      in   synchronous active-high reset (pc <= RESET_PC)
//   load     in   load load_val into pc
//   load_val in   ADDR_W  value loaded when load is high
//   inc      in   increment pc by one
//   pc       out  ADDR_W  current program counter
module instr_fetch_pc_reg
    import instr_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: non-pipelined instruction fetch stage, one instruction in flight.
// Requests a word at pc, holds it on if_* until downstream accepts, then either
// fetches the next sequential word, follows a redirect, or halts for good.
// Optional build macro IFETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt.
//   clk, rst                   clock, synchronous active-high reset
//   imem_req/imem_addr         fetch request and word address (0 when idle)
//   imem_ready/imem_rdata      memory response strobe and data
//   if_valid/if_ready          downstream handshake
//   if_instr/if_pc             instruction word and its address
//   redirect/redirect_target   branch taken for the accepted instruction
//   halt                       accepted instruction is HALT
//   halted                     fetch permanently stopped until reset
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               halt,
    output logic               halted
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              fetch_done;
    logic              accept;
    logic              pc_load;

    assign fetch_done = (state == FS_FETCH) && imem_ready;
    // if_valid is only ever high in FS_HOLD, so this is the accept condition.
    assign accept     = (state == FS_HOLD) && if_valid && if_ready;
    // halt wins over redirect: a halted fetch never reloads the PC.
    assign pc_load    = accept && !halt && redirect;

    assign imem_req  = (state == FS_FETCH);
    assign imem_addr = imem_req ? pc : '0;

    instr_fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_val (redirect_target),
        .inc      (fetch_done),
        .pc       (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FS_FETCH;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
            halted   <= 1'b0;
        end else begin
            unique case (state)
                FS_FETCH: begin
                    if (imem_ready) begin
                        if_instr <= imem_rdata;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        state    <= FS_HOLD;
                    end
                end
                FS_HOLD: begin
                    if (accept) begin
                        if_valid <= 1'b0;
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= FS_HALTED;
                        end else begin
                            state  <= FS_FETCH;
                        end
                    end
                end
                FS_HALTED: begin
                    if_valid <= 1'b0;
                    halted   <= 1'b1;
                end
                default: begin
                    state <= FS_FETCH;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    logic stall;

    // Stalls only counted in FETCH/HOLD, which also freezes both counters once halted.
    assign stall = ((state == FS_FETCH) && !imem_ready) ||
                   ((state == FS_HOLD) && !if_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept && (perf_fetch_cnt != '1)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (stall && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a directed vector table, a hand-written
// halt sequence, then randomized traffic checked against a transaction model.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        redirect;
    logic [15:0] redirect_target;
    logic        halt;
    logic        halted;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    instr_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt            (halt),
        .halted          (halted)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: two fixed words, the rest a simple pattern.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h1123;
        if (a == 16'h0001) return 16'h2456;
        return a ^ 16'hC3A5;
    endfunction

    // Transaction-level reference model.
    logic [15:0] m_pc;
    logic        m_have;
    logic        m_stop;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;
    logic [31:0] m_fetch_cnt;
    logic [31:0] m_stall_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_step(input logic r, input logic rdy, input logic irdy,
                              input logic rd, input logic [15:0] tgt, input logic hlt);
        if (r) begin
            m_pc = 16'h0000; m_have = 1'b0; m_stop = 1'b0;
            m_instr = 16'h0000; m_ipc = 16'h0000;
            m_fetch_cnt = 32'd0; m_stall_cnt = 32'd0;
        end else if (!m_stop) begin
            if (!m_have) begin
                if (rdy) begin
                    m_instr = mem_word(m_pc);
                    m_ipc   = m_pc;
                    m_pc    = m_pc + 16'd1;
                    m_have  = 1'b1;
                end else begin
                    m_stall_cnt = sat_inc(m_stall_cnt);
                end
            end else if (irdy) begin
                m_fetch_cnt = sat_inc(m_fetch_cnt);
                m_have = 1'b0;
                if (hlt) m_stop = 1'b1;
                else if (rd) m_pc = tgt;
            end else begin
                m_stall_cnt = sat_inc(m_stall_cnt);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drives one cycle of inputs, lets the clock edge happen, advances the model.
    task automatic cycle(input logic r, input logic rdy, input logic irdy,
                         input logic rd, input logic [15:0] tgt, input logic hlt);
        rst = r; imem_ready = rdy; if_ready = irdy;
        redirect = rd; redirect_target = tgt; halt = hlt;
        imem_rdata = rdy ? mem_word(imem_addr) : 16'($urandom);
        @(posedge clk);
        model_step(r, rdy, irdy, rd, tgt, hlt);
        #1;
    endtask

    task automatic check_model();
        logic exp_req;
        exp_req = !m_stop && !m_have;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        chk("imem_addr", 32'(imem_addr), exp_req ? 32'(m_pc) : 32'd0);
        chk("if_valid", 32'(if_valid), 32'(m_have));
        chk("if_instr", 32'(if_instr), 32'(m_instr));
        chk("if_pc", 32'(if_pc), 32'(m_ipc));
        chk("halted", 32'(halted), 32'(m_stop));
`ifdef IFETCH_PERF_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, m_fetch_cnt);
        chk("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
`endif
    endtask

    typedef struct {
        logic [3:0]  ctl;    // {rst, imem_ready, if_ready, redirect}
        logic [15:0] tgt;
        logic        hlt;
        logic [2:0]  flags;  // expected {imem_req, if_valid, halted}
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] pc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [3:0] ctl, input logic [15:0] tgt,
                                input logic hlt, input logic [2:0] flags,
                                input logic [15:0] addr, input logic [15:0] instr,
                                input logic [15:0] pc);
        vec_t v;
        v.ctl = ctl; v.tgt = tgt; v.hlt = hlt; v.flags = flags;
        v.addr = addr; v.instr = instr; v.pc = pc;
        tbl.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; imem_ready = 1'b0; if_ready = 1'b0; redirect = 1'b0;
        redirect_target = 16'h0000; halt = 1'b0; imem_rdata = 16'h0000;

        // Zero-wait fetches of addr 0/1 with if_ready high.
        add(4'b1000, 16'h0000, 1'b0, 3'b100, 16'h0000, 16'h0000, 16'h0000);
        add(4'b0100, 16'h0000, 1'b0, 3'b010, 16'h0000, 16'h1123, 16'h0000);
        add(4'b0010, 16'h0000, 1'b0, 3'b100, 16'h0001, 16'h1123, 16'h0000);
        add(4'b0100, 16'h0000, 1'b0, 3'b010, 16'h0000, 16'h2456, 16'h0001);
        add(4'b0010, 16'h0000, 1'b0, 3'b100, 16'h0002, 16'h2456, 16'h0001);
        // Memory response delayed three cycles.
        for (int i = 0; i < 3; i++)
            add(4'b0000, 16'h0000, 1'b0, 3'b100, 16'h0002, 16'h2456, 16'h0001);
        add(4'b0100, 16'h0000, 1'b0, 3'b010, 16'h0000, 16'hC3A7, 16'h0002);
        // Downstream stalls five cycles in HOLD.
        for (int i = 0; i < 5; i++)
            add(4'b0000, 16'h0000, 1'b0, 3'b010, 16'h0000, 16'hC3A7, 16'h0002);
        // Accept with redirect, then redirects outside accept are ignored.
        add(4'b0011, 16'h0040, 1'b0, 3'b100, 16'h0040, 16'hC3A7, 16'h0002);
        add(4'b0001, 16'h1234, 1'b0, 3'b100, 16'h0040, 16'hC3A7, 16'h0002);
        add(4'b0101, 16'h1234, 1'b0, 3'b010, 16'h0000, 16'hC3E5, 16'h0040);
        add(4'b0001, 16'h1234, 1'b0, 3'b010, 16'h0000, 16'hC3E5, 16'h0040);
        add(4'b0010, 16'h0000, 1'b0, 3'b100, 16'h0041, 16'hC3E5, 16'h0040);
        add(4'b0100, 16'h0000, 1'b0, 3'b010, 16'h0000, 16'hC3E4, 16'h0041);
        // Halt together with redirect: halt wins; later strobes are ignored.
        add(4'b0011, 16'h0080, 1'b1, 3'b001, 16'h0000, 16'hC3E4, 16'h0041);
        for (int i = 0; i < 3; i++)
            add(4'b0110, 16'h0000, 1'b1, 3'b001, 16'h0000, 16'hC3E4, 16'h0041);
        // Reset out of HALTED, redirect to FFFF and wrap to 0000.
        add(4'b1000, 16'h0000, 1'b0, 3'b100, 16'h0000, 16'h0000, 16'h0000);
        add(4'b0100, 16'h0000, 1'b0, 3'b010, 16'h0000, 16'h1123, 16'h0000);
        add(4'b0011, 16'hFFFF, 1'b0, 3'b100, 16'hFFFF, 16'h1123, 16'h0000);
        add(4'b0100, 16'h0000, 1'b0, 3'b010, 16'h0000, 16'h3C5A, 16'hFFFF);
        add(4'b0010, 16'h0000, 1'b0, 3'b100, 16'h0000, 16'h3C5A, 16'hFFFF);
        add(4'b0100, 16'h0000, 1'b0, 3'b010, 16'h0000, 16'h1123, 16'h0000);
        add(4'b0010, 16'h0000, 1'b0, 3'b100, 16'h0001, 16'h1123, 16'h0000);
        // Reset while a fetch is outstanding (even with a strobe that cycle).
        add(4'b0000, 16'h0000, 1'b0, 3'b100, 16'h0001, 16'h1123, 16'h0000);
        add(4'b1100, 16'h0000, 1'b0, 3'b100, 16'h0000, 16'h0000, 16'h0000);
        add(4'b0000, 16'h0000, 1'b0, 3'b100, 16'h0000, 16'h0000, 16'h0000);

        foreach (tbl[i]) begin
            cycle(tbl[i].ctl[3], tbl[i].ctl[2], tbl[i].ctl[1], tbl[i].ctl[0],
                  tbl[i].tgt, tbl[i].hlt);
            chk($sformatf("vec%0d.imem_req", i), 32'(imem_req), 32'(tbl[i].flags[2]));
            chk($sformatf("vec%0d.if_valid", i), 32'(if_valid), 32'(tbl[i].flags[1]));
            chk($sformatf("vec%0d.halted", i), 32'(halted), 32'(tbl[i].flags[0]));
            chk($sformatf("vec%0d.imem_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
            chk($sformatf("vec%0d.if_instr", i), 32'(if_instr), 32'(tbl[i].instr));
            chk($sformatf("vec%0d.if_pc", i), 32'(if_pc), 32'(tbl[i].pc));
        end

        // Halted stays silent for 20 cycles despite strobes, then reset restarts.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0200, 1'b0);
            chk("halt_hold.imem_req", 32'(imem_req), 32'd0);
            chk("halt_hold.halted", 32'(halted), 32'd1);
            chk("halt_hold.if_valid", 32'(if_valid), 32'd0);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("restart.imem_req", 32'(imem_req), 32'd1);
        chk("restart.imem_addr", 32'(imem_addr), 32'h0000);
        chk("restart.halted", 32'(halted), 32'd0);

        // Randomized traffic against the model.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        check_model();
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            cycle(($urandom_range(0, 249) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 3) == 0),
                  tgt,
                  ($urandom_range(0, 63) == 0));
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
